// File: rtl/d_reg_bank_if.sv
// d_reg_bank_if: channel bus for the d_reg_bank register bank.
// Optional par/perr signals exist only with D_REG_BANK_PARITY_EN.
interface d_reg_bank_if #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4
);
    logic [CHANNELS-1:0]       en;
    logic [1:0]                mode;
    logic [CHANNELS*WIDTH-1:0] d;
    logic [CHANNELS-1:0]       sin;
    logic [CHANNELS*WIDTH-1:0] q;
    logic [CHANNELS*WIDTH-1:0] q_bar;
    logic [CHANNELS-1:0]       sout;
    logic [CHANNELS-1:0]       changed;
`ifdef D_REG_BANK_PARITY_EN
    logic [CHANNELS-1:0]       par;
    logic                      perr;

    modport master (
        output en, mode, d, sin,
        input  q, q_bar, sout, changed, par, perr
    );
    modport slave (
        input  en, mode, d, sin,
        output q, q_bar, sout, changed, par, perr
    );
`else
    modport master (
        output en, mode, d, sin,
        input  q, q_bar, sout, changed
    );
    modport slave (
        input  en, mode, d, sin,
        output q, q_bar, sout, changed
    );
`endif
endinterface

// File: rtl/d_reg_bank.sv
// d_reg_bank: CHANNELS independent WIDTH-bit registers with load/hold/
// shift/clear, change detect; parity under D_REG_BANK_PARITY_EN.
module d_reg_bank #(
    parameter int               WIDTH     = 8,
    parameter int               CHANNELS  = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input logic          clk,
    input logic          rst,
    d_reg_bank_if.slave  bus
);
    localparam logic [1:0] MODE_LOAD  = 2'b00;
    localparam logic [1:0] MODE_SHIFT = 2'b10;
    localparam logic [1:0] MODE_CLEAR = 2'b11;

    logic [CHANNELS*WIDTH-1:0] r_q;
    logic [CHANNELS*WIDTH-1:0] w_q_nxt;
    logic [CHANNELS-1:0]       r_chg;
    logic [CHANNELS-1:0]       w_chg_nxt;
    logic [CHANNELS-1:0]       w_wr;
    logic [CHANNELS-1:0]       w_sout;

    // Next-state per channel; unknown or hold modes keep the value.
    always_comb begin
        w_q_nxt   = r_q;
        w_chg_nxt = '0;
        w_wr      = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (bus.en[i]) begin
                case (bus.mode)
                    MODE_LOAD: begin
                        w_q_nxt[i*WIDTH +: WIDTH] = bus.d[i*WIDTH +: WIDTH];
                        w_wr[i] = 1'b1;
                    end
                    MODE_SHIFT: begin
                        w_q_nxt[i*WIDTH +: WIDTH] =
                            {r_q[i*WIDTH +: WIDTH-1], bus.sin[i]};
                        w_wr[i] = 1'b1;
                    end
                    MODE_CLEAR: begin
                        w_q_nxt[i*WIDTH +: WIDTH] = '0;
                        w_wr[i] = 1'b1;
                    end
                    default: ;
                endcase
            end
            w_chg_nxt[i] =
                (w_q_nxt[i*WIDTH +: WIDTH] != r_q[i*WIDTH +: WIDTH]);
        end
    end

    // Storage and change-detect flags, reset asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q   <= {CHANNELS{RESET_VAL}};
            r_chg <= '0;
        end else begin
            r_q   <= w_q_nxt;
            r_chg <= w_chg_nxt;
        end
    end

    // Serial-out taps the current MSB of each channel.
    always_comb begin
        w_sout = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            w_sout[i] = r_q[i*WIDTH + WIDTH-1];
        end
    end

    assign bus.q       = r_q;
    assign bus.q_bar   = ~r_q;
    assign bus.sout    = w_sout;
    assign bus.changed = r_chg;

`ifdef D_REG_BANK_PARITY_EN
    logic [CHANNELS-1:0] r_par;
    logic [CHANNELS-1:0] w_par_nxt;
    logic [CHANNELS-1:0] w_par_bad;

    // Parity follows each written value; hold keeps the stored bit.
    always_comb begin
        w_par_nxt = r_par;
        for (int i = 0; i < CHANNELS; i++) begin
            if (w_wr[i]) begin
                w_par_nxt[i] = ^w_q_nxt[i*WIDTH +: WIDTH];
            end
        end
    end

    // Parity register, reset to the parity of the reset value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_par <= {CHANNELS{^RESET_VAL}};
        end else begin
            r_par <= w_par_nxt;
        end
    end

    // Compare stored parity against live contents of each channel.
    always_comb begin
        w_par_bad = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            w_par_bad[i] = r_par[i] ^ (^r_q[i*WIDTH +: WIDTH]);
        end
    end

    assign bus.par  = r_par;
    assign bus.perr = |w_par_bad;
`else
    // Write strobes only feed parity; consumed here to keep them live.
    logic w_wr_unused;
    assign w_wr_unused = ^w_wr;
`endif
endmodule

// File: doc/d_reg_bank.md
Name: d_reg_bank

Overview:
- Parametrised multi-channel D-storage bank, the clocked and generalised successor to the single-bit NOR-gate D latch.
- CHANNELS independent WIDTH-bit registers. Each channel has an enable, a shared mode select (load / hold / serial shift / clear), true and complement outputs, and a one-cycle change-detect pulse.
- Used as the general-purpose state-holding element for datapath and control blocks.

Parameters:
- WIDTH, 8, bits per channel register (>=2)
- CHANNELS, 4, number of independent channel registers (>=1)
- RESET_VAL, 0, WIDTH-bit value loaded into every channel on reset

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- en  input  CHANNELS  per-channel enable; bit i gates channel i
- mode  input  2  shared operation select: 00 load, 01 hold, 10 shift, 11 clear
- d  input  CHANNELS*WIDTH  parallel data; channel i occupies bits [i*WIDTH +: WIDTH]
- sin  input  CHANNELS  serial-in bit per channel (shift mode)
- q  output  CHANNELS*WIDTH  stored values, same packing as d
- q_bar  output  CHANNELS*WIDTH  bitwise complement of q, always
- sout  output  CHANNELS  serial-out per channel = q[i*WIDTH + WIDTH-1] (current MSB)
- changed  output  CHANNELS  registered one-cycle pulse: channel value differed after the last edge

Behaviour:
- Reset (rst=1, asynchronous, independent of clk):
  - every channel q = RESET_VAL; q_bar = ~RESET_VAL
  - changed = 0; sout = MSB of RESET_VAL
  - Reset asserted mid-operation overrides any in-progress load/shift immediately, without waiting for a clock edge.
- Reset release: the first rising edge with rst=0 performs a normal operation. There are no dead cycles.
- Per channel i at each rising clk edge with rst=0:
  - en[i]=0: channel holds regardless of mode.
  - en[i]=1, mode 00 (load): q_i <= d_i.
  - en[i]=1, mode 01 (hold): q_i unchanged.
  - en[i]=1, mode 10 (shift): q_i <= {q_i[WIDTH-2:0], sin[i]}. The MSB shifted out was visible on sout[i] before the edge.
  - en[i]=1, mode 11 (clear): q_i <= 0. This clears to all-zero, not to RESET_VAL.
- Latency:
  - q updates on the same edge as the operation, so it is visible one cycle after inputs are sampled.
  - q_bar and sout are combinational from q, with zero added latency.
- changed[i]:
  - Registered alongside q; set to 1 for exactly one cycle when the newly stored q_i != the previous q_i.
  - Loading an identical value, holding, or clearing an already-zero channel gives changed[i]=0.
  - Consecutive changing edges keep changed[i]=1 on each cycle.
- Channels are fully independent: mixed en patterns apply the shared mode only to enabled channels.
- No undefined states: all mode encodings are defined. An X on mode with en[i]=0 must not corrupt channel i.
- No combinational path from d, sin, en or mode to any output.

Optional Feature:
- Macro: D_REG_BANK_PARITY_EN.
- With the macro defined:
  - Add output port par (CHANNELS bits).
  - par[i] is an even-parity bit stored alongside channel i. It is computed from the value written on each load/shift/clear edge and reset to the parity of RESET_VAL.
  - Add output perr (1 bit), combinational: 1 if any par[i] != XOR-reduce(q_i). Perr is 0 in correct operation; verification forces q to check it.
- Without the macro: the par and perr ports are absent and no parity logic exists.

Test Plan:
- Reset:
  - Stimulus: WIDTH=8, CHANNELS=4, RESET_VAL=8'hA5; assert rst mid-cycle between edges.
  - Required: all q=A5 and q_bar=5A immediately (before the next edge); changed=0; sout=1.
- Load/hold:
  - Stimulus: en=4'b0101, mode=00, d={8'h11,8'h22,8'h33,8'h44} (ch3..ch0).
  - Required after the edge: ch0=44, ch2=22, ch1 and ch3 still A5; changed=4'b0101.
  - Next cycle: mode=01 → values unchanged, changed=0.
- Shift:
  - Stimulus: ch0 loaded with 8'h81, then 3 shift edges with en[0]=1 and sin[0]=1,0,1.
  - Required: sout[0] before each edge =1,0,0; ch0 becomes 8'h03, 8'h06, 8'h0D.
- Clear and change detection:
  - Stimulus: clear ch1 holding 8'h00, then clear ch2 holding 8'h22.
  - Required: changed[1]=0 on the first edge; changed[2]=1 for one cycle on the second; q_bar ch2=FF.
- Reset during shift:
  - Stimulus: assert rst asynchronously during a shift burst, release, then immediately load d_ch0=8'h7E.
  - Required: q returns to A5 with no clock edge; the first post-release edge stores 7E with changed[0]=1.
- Parity (with D_REG_BANK_PARITY_EN):
  - Stimulus: load ch0=8'h07.
  - Required: par[0]=1, perr=0; forcing q ch0 to 8'h06 gives perr=1.
